// File: rtl/register_file.sv
// register_file -- architectural register file with ROB rename tags.
//
// Holds one committed 32-bit value and one pending-producer ROB tag per
// architectural register. Tag 0 means "no pending producer" (value valid).
//
// Ports:
//   clk_in            rising-edge clock
//   rst_in            asynchronous active-high reset (clears values and tags)
//   rdy_in            global enable; all state holds while low
//   clr_in            misprediction flush: clears every tag, keeps values
//   dc_rename_valid   decode renames dc_rename_rd to ROB tag dc_rename_index
//   dc_rename_rd      destination register of the renaming instruction
//   dc_rename_index   new ROB tag for that destination
//   dc_rs1, dc_rs2    combinational source register queries
//   reg_rs1_val/_dep  value and pending tag for dc_rs1 (dep 0 => value valid)
//   reg_rs2_val/_dep  value and pending tag for dc_rs2
//   rob_commit        commit strobe from the ROB
//   rob_commit_rd     committed destination register
//   rob_commit_index  ROB tag of the committing instruction
//   rob_commit_val    committed result
//   reg_pending_cnt   number of registers x1.. with a nonzero tag
module register_file #(
  parameter int REG_NUM         = 32,
  parameter int ROB_INDEX_WIDTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clr_in,
  input  logic                       dc_rename_valid,
  input  logic [4:0]                 dc_rename_rd,
  input  logic [ROB_INDEX_WIDTH-1:0] dc_rename_index,
  input  logic [4:0]                 dc_rs1,
  input  logic [4:0]                 dc_rs2,
  output logic [31:0]                reg_rs1_val,
  output logic [31:0]                reg_rs2_val,
  output logic [ROB_INDEX_WIDTH-1:0] reg_rs1_dep,
  output logic [ROB_INDEX_WIDTH-1:0] reg_rs2_dep,
  input  logic                       rob_commit,
  input  logic [4:0]                 rob_commit_rd,
  input  logic [ROB_INDEX_WIDTH-1:0] rob_commit_index,
  input  logic [31:0]                rob_commit_val,
  output logic [5:0]                 reg_pending_cnt
);

  logic [31:0]                val [REG_NUM];
  logic [ROB_INDEX_WIDTH-1:0] tag [REG_NUM];

  // x0 is hardwired and registers beyond REG_NUM do not exist.
  function automatic logic writable(input logic [4:0] r);
    return (r != 5'd0) && (int'(r) < REG_NUM);
  endfunction

  logic commit_ok;
  logic rename_ok;

  assign commit_ok = rob_commit && writable(rob_commit_rd);
  assign rename_ok = dc_rename_valid && writable(dc_rename_rd) && !clr_in;

  // ---------------------------------------------------------------------
  // Query path: zero-latency read with same-cycle commit forwarding.
  // Renames issued this cycle are not visible until the next edge.
  // ---------------------------------------------------------------------
  logic [4:0]                 qry_rs  [2];
  logic [31:0]                qry_val [2];
  logic [ROB_INDEX_WIDTH-1:0] qry_dep [2];

  always_comb begin
    qry_rs[0] = dc_rs1;
    qry_rs[1] = dc_rs2;
    for (int unsigned p = 0; p < 2; p++) begin
      qry_val[p] = '0;
      qry_dep[p] = '0;
      if (writable(qry_rs[p])) begin
        // Forward only when the committing tag is still the live mapping;
        // a stale commit must not hide a newer pending producer.
        if (commit_ok && (rob_commit_rd == qry_rs[p]) &&
            (tag[qry_rs[p]] == rob_commit_index)) begin
          qry_val[p] = rob_commit_val;
          qry_dep[p] = '0;
        end else begin
          qry_val[p] = val[qry_rs[p]];
          qry_dep[p] = tag[qry_rs[p]];
        end
      end
    end
  end

  assign reg_rs1_val = qry_val[0];
  assign reg_rs1_dep = qry_dep[0];
  assign reg_rs2_val = qry_val[1];
  assign reg_rs2_dep = qry_dep[1];

  // ---------------------------------------------------------------------
  // Pending-producer count over x1..x(REG_NUM-1).
  // ---------------------------------------------------------------------
  always_comb begin
    reg_pending_cnt = '0;
    for (int unsigned i = 1; i < 32'(REG_NUM); i++) begin
      if (tag[i] != '0) reg_pending_cnt = reg_pending_cnt + 6'd1;
    end
  end

  // ---------------------------------------------------------------------
  // State update. Statement order encodes priority: the tag clear from a
  // commit is overridden by a flush, and a same-cycle rename of the same rd
  // overrides the commit's clear. Value writes from commits always happen.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < 32'(REG_NUM); i++) begin
        val[i] <= '0;
        tag[i] <= '0;
      end
    end else if (rdy_in) begin
      if (commit_ok) begin
        val[rob_commit_rd] <= rob_commit_val;
        if (tag[rob_commit_rd] == rob_commit_index) begin
          tag[rob_commit_rd] <= '0;
        end
      end
      if (clr_in) begin
        for (int unsigned i = 0; i < 32'(REG_NUM); i++) begin
          tag[i] <= '0;
        end
      end else if (rename_ok) begin
        tag[dc_rename_rd] <= dc_rename_index;
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam int RIW = 4;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           rdy_in;
  logic           clr_in;
  logic           dc_rename_valid;
  logic [4:0]     dc_rename_rd;
  logic [RIW-1:0] dc_rename_index;
  logic [4:0]     dc_rs1;
  logic [4:0]     dc_rs2;
  logic [31:0]    reg_rs1_val;
  logic [31:0]    reg_rs2_val;
  logic [RIW-1:0] reg_rs1_dep;
  logic [RIW-1:0] reg_rs2_dep;
  logic           rob_commit;
  logic [4:0]     rob_commit_rd;
  logic [RIW-1:0] rob_commit_index;
  logic [31:0]    rob_commit_val;
  logic [5:0]     reg_pending_cnt;

  register_file #(.REG_NUM(32), .ROB_INDEX_WIDTH(RIW)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clr_in           (clr_in),
    .dc_rename_valid  (dc_rename_valid),
    .dc_rename_rd     (dc_rename_rd),
    .dc_rename_index  (dc_rename_index),
    .dc_rs1           (dc_rs1),
    .dc_rs2           (dc_rs2),
    .reg_rs1_val      (reg_rs1_val),
    .reg_rs2_val      (reg_rs2_val),
    .reg_rs1_dep      (reg_rs1_dep),
    .reg_rs2_dep      (reg_rs2_dep),
    .rob_commit       (rob_commit),
    .rob_commit_rd    (rob_commit_rd),
    .rob_commit_index (rob_commit_index),
    .rob_commit_val   (rob_commit_val),
    .reg_pending_cnt  (reg_pending_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    bit          port;
    logic [4:0]  rs;
    logic [31:0] val;
    logic [3:0]  dep;
    logic [5:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic expect_q(input string name, input bit port, input logic [4:0] rs,
                          input logic [31:0] v, input logic [3:0] dep, input logic [5:0] cnt);
    exp_t e;
    e.name = name; e.port = port; e.rs = rs; e.val = v; e.dep = dep; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Pop each expectation, steer the query port, and compare once settled.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) dc_rs2 = e.rs; else dc_rs1 = e.rs;
      #1;
      if (e.port) begin
        check({e.name, ".val"}, reg_rs2_val, e.val);
        check({e.name, ".dep"}, 32'(reg_rs2_dep), 32'(e.dep));
      end else begin
        check({e.name, ".val"}, reg_rs1_val, e.val);
        check({e.name, ".dep"}, 32'(reg_rs1_dep), 32'(e.dep));
      end
      check({e.name, ".cnt"}, 32'(reg_pending_cnt), 32'(e.cnt));
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    dc_rename_valid = 1'b0;
    rob_commit      = 1'b0;
    clr_in          = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] idx);
    dc_rename_valid = 1'b1;
    dc_rename_rd    = rd;
    dc_rename_index = idx;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] idx, input logic [31:0] v);
    rob_commit       = 1'b1;
    rob_commit_rd    = rd;
    rob_commit_index = idx;
    rob_commit_val   = v;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
    dc_rename_valid = 1'b0; dc_rename_rd = '0; dc_rename_index = '0;
    dc_rs1 = '0; dc_rs2 = '0;
    rob_commit = 1'b0; rob_commit_rd = '0; rob_commit_index = '0; rob_commit_val = '0;
    #3;
    expect_q("reset", 0, 5'd5, 32'h0, 4'd0, 6'd0);
    drain();
    #8 rst_in = 1'b0;
    tick();

    // Rename, query, forward, retire.
    rename(5'd5, 4'd3);
    expect_q("ren_same_cycle", 0, 5'd5, 32'h0, 4'd0, 6'd0);
    drain();
    tick();
    expect_q("ren_dep", 0, 5'd5, 32'h0, 4'd3, 6'd1);
    drain();
    commit(5'd5, 4'd3, 32'hDEADBEEF);
    expect_q("fwd_rs1", 0, 5'd5, 32'hDEADBEEF, 4'd0, 6'd1);
    expect_q("fwd_rs2", 1, 5'd5, 32'hDEADBEEF, 4'd0, 6'd1);
    drain();
    tick();
    expect_q("retired", 0, 5'd5, 32'hDEADBEEF, 4'd0, 6'd0);
    drain();

    // Stale commit must not clear a newer rename.
    rename(5'd7, 4'd2); tick();
    rename(5'd7, 4'd4); tick();
    commit(5'd7, 4'd2, 32'h11);
    expect_q("stale_nofwd", 0, 5'd7, 32'h0, 4'd4, 6'd1);
    drain();
    tick();
    expect_q("stale_val", 0, 5'd7, 32'h11, 4'd4, 6'd1);
    drain();
    commit(5'd7, 4'd4, 32'h22);
    expect_q("live_fwd", 1, 5'd7, 32'h22, 4'd0, 6'd1);
    drain();
    tick();
    expect_q("live_done", 0, 5'd7, 32'h22, 4'd0, 6'd0);
    drain();

    // Rename and commit on the same rd: rename wins the tag.
    rename(5'd9, 4'd5); tick();
    rename(5'd9, 4'd6);
    commit(5'd9, 4'd5, 32'h33);
    expect_q("coll_fwd", 0, 5'd9, 32'h33, 4'd0, 6'd1);
    drain();
    tick();
    expect_q("coll_after", 0, 5'd9, 32'h33, 4'd6, 6'd1);
    drain();
    commit(5'd9, 4'd6, 32'h33); tick();
    expect_q("coll_clean", 0, 5'd9, 32'h33, 4'd0, 6'd0);
    drain();

    // Flush with coincident commit and rename.
    rename(5'd1, 4'd1); tick();
    rename(5'd2, 4'd2); tick();
    rename(5'd3, 4'd3); tick();
    expect_q("pre_clr", 1, 5'd2, 32'h0, 4'd2, 6'd3);
    drain();
    clr_in = 1'b1;
    commit(5'd1, 4'd1, 32'h44);
    rename(5'd4, 4'd5);
    tick();
    expect_q("clr_x1", 0, 5'd1, 32'h44, 4'd0, 6'd0);
    expect_q("clr_x2", 1, 5'd2, 32'h0, 4'd0, 6'd0);
    expect_q("clr_x3", 0, 5'd3, 32'h0, 4'd0, 6'd0);
    expect_q("clr_x4", 1, 5'd4, 32'h0, 4'd0, 6'd0);
    drain();

    // x0 writes are ignored.
    rename(5'd10, 4'd1); tick();
    rename(5'd0, 4'd7);
    commit(5'd0, 4'd7, 32'hFF);
    expect_q("x0_same", 0, 5'd0, 32'h0, 4'd0, 6'd1);
    drain();
    tick();
    expect_q("x0_after", 1, 5'd0, 32'h0, 4'd0, 6'd1);
    drain();

    // rdy_in low freezes state.
    rdy_in = 1'b0;
    commit(5'd10, 4'd1, 32'h55);
    rename(5'd11, 4'd2);
    tick();
    rdy_in = 1'b1;
    expect_q("stall_x10", 0, 5'd10, 32'h0, 4'd1, 6'd1);
    expect_q("stall_x11", 1, 5'd11, 32'h0, 4'd0, 6'd1);
    drain();

    // Asynchronous reset mid-cycle with pending tags.
    rename(5'd12, 4'd3); tick();
    expect_q("pre_rst", 1, 5'd12, 32'h0, 4'd3, 6'd2);
    drain();
    #1 rst_in = 1'b1;
    #1;
    expect_q("rst_x10", 0, 5'd10, 32'h0, 4'd0, 6'd0);
    expect_q("rst_x12", 1, 5'd12, 32'h0, 4'd0, 6'd0);
    expect_q("rst_x5", 0, 5'd5, 32'h0, 4'd0, 6'd0);
    drain();
    rst_in = 1'b0;
    tick();
    rename(5'd13, 4'd4); tick();
    expect_q("post_rst", 0, 5'd13, 32'h0, 4'd4, 6'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter REG_NUM, default 32: number of architectural registers.
REQ-002 SHALL have parameter ROB_INDEX_WIDTH, default 4: ROB tag width; tag 0 is reserved and means "no pending producer".
REQ-003 SHALL have ports `clk_in` (input, 1): the single clock, rising edge.
REQ-004 SHALL have `rst_in` (input, 1): reset, asynchronous and active-high.
REQ-005 SHALL have `rdy_in` (input, 1): global enable; when low, all state holds.
REQ-006 SHALL have `clr_in` (input, 1): misprediction flush from the ROB.
REQ-007 SHALL have `dc_rename_valid` (input, 1): the issuing instruction renames its rd.
REQ-008 SHALL have `dc_rename_rd` (input, 5) and `dc_rename_index` (input, ROB_INDEX_WIDTH): destination register and its new ROB tag.
REQ-009 SHALL have `dc_rs1` and `dc_rs2` (input, 5 each): source register queries.
REQ-010 SHALL have `reg_rs1_val` and `reg_rs2_val` (output, 32 each): committed or forwarded source values.
REQ-011 SHALL have `reg_rs1_dep` and `reg_rs2_dep` (output, ROB_INDEX_WIDTH each): pending producer tag; 0 means the value is valid.
REQ-012 SHALL have `rob_commit` (input, 1): a commit strobe from the ROB.
REQ-013 SHALL have `rob_commit_rd` (input, 5), `rob_commit_index` (input, ROB_INDEX_WIDTH) and `rob_commit_val` (input, 32): the committed destination, its tag and its result.
REQ-014 SHALL have `reg_pending_cnt` (output, 6): the number of registers with a nonzero tag.

Function
REQ-015 SHALL hold a 32-bit value array `val[REG_NUM]` and a tag array `tag[REG_NUM]`.
REQ-016 SHALL treat x0 as hardwired: reads return value 0 and dep 0, and renames or commits to x0 are ignored.
REQ-017 Queries SHALL be combinational with zero latency: dep = tag[rs] and value = val[rs].
REQ-018 Commit forwarding SHALL apply in the same cycle: if `rob_commit`, rs == `rob_commit_rd` != 0, and tag[rs] == `rob_commit_index`, then dep = 0 and value = `rob_commit_val`.
REQ-019 Queries SHALL NOT see a rename issued in the same cycle; an instruction whose rd equals its rs reads the old mapping.
REQ-020 On a clock edge with `rdy_in` high and `rob_commit` high and rd != 0, the block SHALL write val[rd] <= `rob_commit_val` unconditionally, whatever the tag.
REQ-021 On the same commit, the block SHALL clear tag[rd] to 0 only if tag[rd] == `rob_commit_index`; an older commit SHALL NOT clear a newer rename.
REQ-022 On a clock edge with `rdy_in` high, `dc_rename_valid` high, rd != 0 and `clr_in` low, the block SHALL write tag[rd] <= `dc_rename_index`.
REQ-023 When a rename and a commit target the same rd in the same cycle, the rename SHALL win: the tag becomes the new index, and the value write still occurs.
REQ-024 On `clr_in` high (with `rdy_in` high), all tags SHALL be set to 0 and any rename SHALL be discarded.
REQ-025 On `clr_in`, values SHALL be retained, and a coincident commit's value write SHALL still be performed.
REQ-026 With `rdy_in` low, no array SHALL change, and combinational outputs SHALL still reflect current state.
REQ-027 `reg_pending_cnt` SHALL be the combinational popcount of the nonzero tags for x1..x31 (range 0..31).
REQ-028 The block SHALL contain no internal FSM beyond the arrays; every update SHALL take exactly one clock edge.

Reset
REQ-029 Asserting `rst_in` SHALL, immediately and independent of the clock, set all val to 0 and all tag to 0, giving all reg_*_val = 0, all reg_*_dep = 0 and `reg_pending_cnt` = 0.
REQ-030 Reset SHALL take priority over `clr_in`, `rdy_in`, rename and commit; in-flight renames are lost, and after deassertion the block SHALL accept operations on the next edge.

Verification
REQ-031 The bench SHALL rename x5 to tag 3, then query rs1=x5. Required: dep=3 and `reg_pending_cnt`=1. Then commit (x5, 3, 0xDEADBEEF). Required in the same cycle: rs1 value 0xDEADBEEF with dep 0. Required next cycle: tag 0 and count 0.
REQ-032 The bench SHALL rename x7 to tag 2, then rename x7 to tag 4, then commit (x7, 2, 0x11). Required: val[x7]=0x11 and dep stays 4. Then commit (x7, 4, 0x22). Required: dep 0 and value 0x22.
REQ-033 The bench SHALL apply, in one cycle, a rename of x9 to tag 6 and a commit of (x9, 5, 0x33), with tag[x9]=5 before the cycle. Required: tag[x9]=6 and val[x9]=0x33.
REQ-034 The bench SHALL rename x1, x2 and x3 to tags 1, 2 and 3, then assert `clr_in` together with commit (x1, 1, 0x44) and a rename of x4 to tag 5. Required: all deps 0, val[x1]=0x44, x4 not renamed, and count 0.
REQ-035 The bench SHALL attempt a rename of x0 to tag 7 and a commit of (x0, 7, 0xFF). Required: rs1=x0 returns 0 with dep 0 and count unchanged. It SHALL also hold `rdy_in` low during a commit. Required: no state change.
REQ-036 The bench SHALL assert `rst_in` asynchronously mid-cycle with pending tags present. Required: outputs zero before the next edge.
